// File: rtl/clock_set_core.sv
// Time-of-day core: prescaled seconds tick, BCD sec/min/hour chain, set mode with inc/dec.
// Optional alarm compare enabled by defining CLOCK_SET_ALARM_EN.
module clock_set_core #(
    parameter int unsigned TICK_DIV     = 1,
    parameter int unsigned HOUR_MODULUS = 24
) (
    input  logic       clk_i,
    input  logic       cr_i,
    input  logic       run_i,
    input  logic [1:0] set_sel_i,
    input  logic       set_inc_i,
    input  logic       set_dec_i,
`ifdef CLOCK_SET_ALARM_EN
    input  logic       alarm_set_i,
    input  logic [7:0] alarm_hour_i,
    input  logic [7:0] alarm_minute_i,
    output logic       alarm_o,
`endif
    output logic [7:0] second_o,
    output logic [7:0] minute_o,
    output logic [7:0] hour_o,
    output logic       sec_pulse_o,
    output logic       day_pulse_o
);

    localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);
    localparam logic [7:0] HourMax = (HOUR_MODULUS == 12) ? 8'h11 : 8'h23;
    localparam logic [7:0] MinSecMax = 8'h59;

    logic [PresW-1:0] presc_q, presc_d;
    logic [7:0]       second_q, second_d;
    logic [7:0]       minute_q, minute_d;
    logic [7:0]       hour_q, hour_d;
    logic             sec_pulse_q, sec_pulse_d;
    logic             day_pulse_q, day_pulse_d;
    logic             run_mode;
    logic             tick;
    logic             set_step;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00) begin
            return max;
        end else if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end else begin
            return {v[7:4], v[3:0] - 4'd1};
        end
    endfunction

    assign run_mode = (set_sel_i == 2'b00);
    assign tick     = run_mode && run_i && (presc_q == PresMax);
    // Simultaneous inc and dec cancel out.
    assign set_step = set_inc_i ^ set_dec_i;

    always_comb begin
        presc_d     = presc_q;
        second_d    = second_q;
        minute_d    = minute_q;
        hour_d      = hour_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        if (!run_mode) begin
            presc_d = '0;
            if (set_step) begin
                case (set_sel_i)
                    2'b01: second_d = set_inc_i ? bcd_inc(second_q, MinSecMax)
                                                : bcd_dec(second_q, MinSecMax);
                    2'b10: minute_d = set_inc_i ? bcd_inc(minute_q, MinSecMax)
                                                : bcd_dec(minute_q, MinSecMax);
                    2'b11: hour_d   = set_inc_i ? bcd_inc(hour_q, HourMax)
                                                : bcd_dec(hour_q, HourMax);
                    default: ;
                endcase
            end
        end else if (run_i) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                sec_pulse_d = 1'b1;
                second_d    = bcd_inc(second_q, MinSecMax);
                if (second_q == MinSecMax) begin
                    minute_d = bcd_inc(minute_q, MinSecMax);
                    if (minute_q == MinSecMax) begin
                        hour_d      = bcd_inc(hour_q, HourMax);
                        day_pulse_d = (hour_q == HourMax);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge cr_i) begin
        if (cr_i) begin
            presc_q     <= '0;
            second_q    <= 8'h00;
            minute_q    <= 8'h00;
            hour_q      <= 8'h00;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            second_q    <= second_d;
            minute_q    <= minute_d;
            hour_q      <= hour_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    assign second_o    = second_q;
    assign minute_o    = minute_q;
    assign hour_o      = hour_q;
    assign sec_pulse_o = sec_pulse_q;
    assign day_pulse_o = day_pulse_q;

`ifdef CLOCK_SET_ALARM_EN
    logic [7:0] alarm_hour_q, alarm_minute_q;
    logic       alarm_q, alarm_d;

    // Compare against the post-tick time so the alarm lands with the new time.
    assign alarm_d = tick && (second_d == 8'h00) && (minute_d == alarm_minute_q) &&
                     (hour_d == alarm_hour_q);

    always_ff @(posedge clk_i or posedge cr_i) begin
        if (cr_i) begin
            alarm_hour_q   <= 8'h00;
            alarm_minute_q <= 8'h00;
            alarm_q        <= 1'b0;
        end else begin
            if (alarm_set_i) begin
                alarm_hour_q   <= alarm_hour_i;
                alarm_minute_q <= alarm_minute_i;
            end
            alarm_q <= alarm_d;
        end
    end

    assign alarm_o = alarm_q;
`endif

endmodule

// File: tb/tb_clock_set_core.sv
// Directed bench for clock_set_core: TICK_DIV=4/24h instance plus a TICK_DIV=1/12h instance.
module tb_clock_set_core;

    logic       clk;
    logic       cr, run, inc, dec;
    logic [1:0] sel;
    logic [7:0] second, minute, hour;
    logic       sec_pulse, day_pulse;

    logic       cr2, run2, inc2, dec2;
    logic [1:0] sel2;
    logic [7:0] second2, minute2, hour2;
    logic       sec_pulse2, day_pulse2;

    int n_tests = 0;
    int n_fail  = 0;

    clock_set_core #(.TICK_DIV(4), .HOUR_MODULUS(24)) u_dut (
        .clk_i      (clk),
        .cr_i       (cr),
        .run_i      (run),
        .set_sel_i  (sel),
        .set_inc_i  (inc),
        .set_dec_i  (dec),
        .second_o   (second),
        .minute_o   (minute),
        .hour_o     (hour),
        .sec_pulse_o(sec_pulse),
        .day_pulse_o(day_pulse)
    );

    clock_set_core #(.TICK_DIV(1), .HOUR_MODULUS(12)) u_dut12 (
        .clk_i      (clk),
        .cr_i       (cr2),
        .run_i      (run2),
        .set_sel_i  (sel2),
        .set_inc_i  (inc2),
        .set_dec_i  (dec2),
        .second_o   (second2),
        .minute_o   (minute2),
        .hour_o     (hour2),
        .sec_pulse_o(sec_pulse2),
        .day_pulse_o(day_pulse2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] sel;
        logic       run;
        logic       inc;
        logic       dec;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [25:0] pack(input logic [7:0] h, input logic [7:0] m,
                                         input logic [7:0] s, input logic sp, input logic dp);
        return {h, m, s, sp, dp};
    endfunction

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got h=%h m=%h s=%h sp=%b dp=%b, want h=%h m=%h s=%h sp=%b dp=%b",
                     name, act[25:18], act[17:10], act[9:2], act[1], act[0],
                     exp[25:18], exp[17:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25:0] dut1();
        return {hour, minute, second, sec_pulse, day_pulse};
    endfunction

    function automatic logic [25:0] dut2();
        return {hour2, minute2, second2, sec_pulse2, day_pulse2};
    endfunction

    initial begin
        vecs[0]  = '{2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01};
        vecs[1]  = '{2'b01, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{2'b01, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h59};
        vecs[3]  = '{2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{2'b10, 1'b1, 1'b0, 1'b1, 8'h00, 8'h59, 8'h00};
        vecs[5]  = '{2'b10, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{2'b10, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{2'b11, 1'b1, 1'b0, 1'b1, 8'h23, 8'h00, 8'h00};
        vecs[8]  = '{2'b11, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{2'b11, 1'b1, 1'b0, 1'b1, 8'h23, 8'h00, 8'h00};
        vecs[10] = '{2'b10, 1'b1, 1'b0, 1'b1, 8'h23, 8'h59, 8'h00};
        vecs[11] = '{2'b01, 1'b1, 1'b0, 1'b1, 8'h23, 8'h59, 8'h59};
        vecs[12] = '{2'b00, 1'b0, 1'b1, 1'b0, 8'h23, 8'h59, 8'h59};

        cr = 1'b0; run = 1'b0; sel = 2'b00; inc = 1'b0; dec = 1'b0;
        cr2 = 1'b0; run2 = 1'b0; sel2 = 2'b00; inc2 = 1'b0; dec2 = 1'b0;
        #2 cr = 1'b1; cr2 = 1'b1;
        #1 check("reset", dut1(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        check("reset12", dut2(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        step();
        cr = 1'b0; cr2 = 1'b0;

        // Set-mode table: no carries, wraps both ways, inc+dec cancel, no pulses.
        for (int i = 0; i < 13; i++) begin
            sel = vecs[i].sel; run = vecs[i].run; inc = vecs[i].inc; dec = vecs[i].dec;
            step();
            check($sformatf("set_vec%0d", i), dut1(),
                  pack(vecs[i].hour, vecs[i].minute, vecs[i].second, 1'b0, 1'b0));
        end

        // Rollover 23:59:59 -> 00:00:00 after 4 enabled cycles.
        sel = 2'b00; inc = 1'b0; dec = 1'b0; run = 1'b1;
        repeat (3) step();
        check("pre_roll", dut1(), pack(8'h23, 8'h59, 8'h59, 1'b0, 1'b0));
        step();
        check("rollover", dut1(), pack(8'h00, 8'h00, 8'h00, 1'b1, 1'b1));
        step();
        check("roll_pulse_end", dut1(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));

        // 40 cycles from clean reset at TICK_DIV=4.
        run = 1'b0;
        cr = 1'b1;
        step();
        cr = 1'b0; run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            check($sformatf("tick_pulse%0d", i), {25'd0, sec_pulse}, {25'd0, (i % 4) == 3});
        end
        check("forty_cycles", dut1(), pack(8'h00, 8'h00, 8'h10, 1'b1, 1'b0));

        // Pause with two counts already accumulated; resume finishes the remaining two.
        repeat (2) step();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold%0d", i), dut1(), pack(8'h00, 8'h00, 8'h10, 1'b0, 1'b0));
        end
        run = 1'b1;
        step();
        check("resume1", dut1(), pack(8'h00, 8'h00, 8'h10, 1'b0, 1'b0));
        step();
        check("resume2", dut1(), pack(8'h00, 8'h00, 8'h11, 1'b1, 1'b0));

        // Brief set-mode visit clears partial prescaler count.
        repeat (2) step();
        sel = 2'b01;
        step();
        check("set_visit", dut1(), pack(8'h00, 8'h00, 8'h11, 1'b0, 1'b0));
        sel = 2'b00;
        repeat (3) step();
        check("restart3", dut1(), pack(8'h00, 8'h00, 8'h11, 1'b0, 1'b0));
        step();
        check("restart4", dut1(), pack(8'h00, 8'h00, 8'h12, 1'b1, 1'b0));

        // Preload 12:34:56 through BCD increments, then async reset mid-count.
        run = 1'b0;
        cr = 1'b1;
        step();
        cr = 1'b0;
        inc = 1'b1;
        sel = 2'b11;
        repeat (12) step();
        sel = 2'b10;
        repeat (34) step();
        sel = 2'b01;
        repeat (56) step();
        inc = 1'b0;
        sel = 2'b00;
        run = 1'b1;
        step();
        check("preload", dut1(), pack(8'h12, 8'h34, 8'h56, 1'b0, 1'b0));
        #2;
        sel = 2'b01; inc = 1'b1;
        cr = 1'b1;
        #1 check("async_reset", dut1(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        step();
        check("reset_held", dut1(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
        cr = 1'b0; inc = 1'b0; sel = 2'b00; run = 1'b0;
        step();
        check("reset_release", dut1(), pack(8'h00, 8'h00, 8'h00, 1'b0, 1'b0));

        // 12-hour instance: 11:59:59 -> 00:00:00 on a single enabled cycle.
        sel2 = 2'b11; dec2 = 1'b1;
        step();
        check("h12_dec", dut2(), pack(8'h11, 8'h00, 8'h00, 1'b0, 1'b0));
        sel2 = 2'b10;
        step();
        sel2 = 2'b01;
        step();
        check("h12_preload", dut2(), pack(8'h11, 8'h59, 8'h59, 1'b0, 1'b0));
        dec2 = 1'b0; sel2 = 2'b00; run2 = 1'b1;
        step();
        check("h12_roll", dut2(), pack(8'h00, 8'h00, 8'h00, 1'b1, 1'b1));
        step();
        check("h12_next", dut2(), pack(8'h00, 8'h00, 8'h01, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
